ysyx_22040237_exu_ctrl: RTL and testbench

YSYX_22040237_EXU_CTRL -- requirements
Module: ysyx_22040237_exu_ctrl

---
 rtl/ysyx_22040237_exu_pkg.sv | 20 ++
 rtl/ysyx_22040237_exu_ctrl_if.sv | 36 +++
 rtl/ysyx_22040237_timeout_cnt.sv | 28 ++
 rtl/ysyx_22040237_exu_ctrl.sv | 124 ++++++++++++
 tb/tb_ysyx_22040237_exu_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040237_exu_pkg.sv
// Shared types and constants for the EXU controller: FSM states, halt codes, opcode width.
package ysyx_22040237_exu_pkg;

    localparam int OPCODE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_RESP     = 2'd2,
        ST_HALT     = 2'd3
    } exu_state_e;

    typedef logic [1:0] halt_code_t;

    localparam halt_code_t HALT_NONE    = 2'b00;
    localparam halt_code_t HALT_EBREAK  = 2'b01;
    localparam halt_code_t HALT_INVALID = 2'b10;
    localparam halt_code_t HALT_TIMEOUT = 2'b11;

endpackage

// File: rtl/ysyx_22040237_exu_ctrl_if.sv
// Bundle between the IDU/MDU/writeback side (master) and the EXU controller (slave).
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid holds with its payload stable until that edge, ready never waits on a future valid.
interface ysyx_22040237_exu_ctrl_if;
    import ysyx_22040237_exu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode;
    logic                in_is_mdu;
    logic                in_ebreak;
    logic                in_invalid;
    logic                alu_en;
    logic                mdu_start;
    logic                mdu_done;
    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] out_opcode;
    logic                halt;
    halt_code_t          halt_code;
    logic [63:0]         retire_cnt;
    exu_state_e          state;

    modport master (
        output in_valid, in_opcode, in_is_mdu, in_ebreak, in_invalid, mdu_done, out_ready,
        input  in_ready, alu_en, mdu_start, out_valid, out_opcode, halt, halt_code,
               retire_cnt, state
    );

    modport slave (
        input  in_valid, in_opcode, in_is_mdu, in_ebreak, in_invalid, mdu_done, out_ready,
        output in_ready, alu_en, mdu_start, out_valid, out_opcode, halt, halt_code,
               retire_cnt, state
    );

endinterface

// File: rtl/ysyx_22040237_timeout_cnt.sv
// MDU wait counter: cleared on launch, counts while enabled, flags the last allowed cycle.
module ysyx_22040237_timeout_cnt #(
    parameter  int LIMIT = 64,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q;

    // Saturates at the terminal count; the FSM always leaves MDU_WAIT there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_22040237_exu_ctrl.sv
// EXU sequencing controller: accepts decoded ops, launches ALU or MDU, presents results
// for writeback, counts retirements and halts on ebreak, invalid op or MDU timeout.
module ysyx_22040237_exu_ctrl
    import ysyx_22040237_exu_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22040237_exu_ctrl_if.slave  bus
);

    exu_state_e          state_q, state_d;
    logic                alu_en_q, alu_en_d;
    logic                mdu_start_q, mdu_start_d;
    logic [OPCODE_W-1:0] opcode_q;
    halt_code_t          halt_code_q, halt_code_d;
    logic [63:0]         retire_q;
    logic                retire_inc;
    logic                accept;
    logic                wait_clr, wait_en, wait_tc;

    assign accept = bus.in_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        alu_en_d    = 1'b0;
        mdu_start_d = 1'b0;
        halt_code_d = halt_code_q;
        retire_inc  = 1'b0;
        wait_clr    = 1'b0;
        wait_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.in_invalid) begin
                        state_d     = ST_HALT;
                        halt_code_d = HALT_INVALID;
                    end else if (bus.in_ebreak) begin
                        state_d     = ST_HALT;
                        halt_code_d = HALT_EBREAK;
                        retire_inc  = 1'b1;
                    end else if (bus.in_is_mdu) begin
                        state_d     = ST_MDU_WAIT;
                        mdu_start_d = 1'b1;
                        wait_clr    = 1'b1;
                    end else begin
                        state_d  = ST_RESP;
                        alu_en_d = 1'b1;
                    end
                end
            end
            ST_MDU_WAIT: begin
                wait_en = 1'b1;
                // A result arriving on the terminal cycle still completes normally.
                if (bus.mdu_done) begin
                    state_d = ST_RESP;
                end else if (wait_tc) begin
                    state_d     = ST_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    state_d    = ST_IDLE;
                    retire_inc = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            alu_en_q    <= 1'b0;
            mdu_start_q <= 1'b0;
            opcode_q    <= '0;
            halt_code_q <= HALT_NONE;
        end else begin
            state_q     <= state_d;
            alu_en_q    <= alu_en_d;
            mdu_start_q <= mdu_start_d;
            halt_code_q <= halt_code_d;
            if (accept) begin
                opcode_q <= bus.in_opcode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (retire_inc) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    ysyx_22040237_timeout_cnt #(
        .LIMIT (MDU_TIMEOUT)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (wait_clr),
        .en  (wait_en),
        .tc  (wait_tc)
    );

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_RESP);
    assign bus.halt       = (state_q == ST_HALT);
    assign bus.alu_en     = alu_en_q;
    assign bus.mdu_start  = mdu_start_q;
    assign bus.out_opcode = opcode_q;
    assign bus.halt_code  = halt_code_q;
    assign bus.retire_cnt = retire_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_ysyx_22040237_exu_ctrl.sv
// Randomised and directed bench for the EXU controller with a queue-based scoreboard.
module tb_ysyx_22040237_exu_ctrl;

    localparam int TIMEOUT  = 8;
    localparam int NO_DONE  = -1;
    localparam int ABANDON  = -2;

    logic clk;
    logic rst;

    ysyx_22040237_exu_ctrl_if bus ();

    ysyx_22040237_exu_ctrl #(.MDU_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [1:0]  exp_halt_q[$];
    logic [63:0] model_retire = 64'd0;
    int          stall_left = 0;
    logic        mon_en = 1'b0;

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected halt code from the instruction flags and MDU completion delay
    function automatic logic [1:0] model_halt(logic mdu, logic eb, logic inv, int delay);
        if (inv) return 2'b10;
        if (eb) return 2'b01;
        if (mdu && (delay < 0 || delay >= TIMEOUT)) return 2'b11;
        return 2'b00;
    endfunction

    // driver tasks
    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_en         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.mdu_done   = 1'b0;
        rst            = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_alu_en", bus.alu_en, 0);
        check("rst_mdu_start", bus.mdu_start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_opcode", bus.out_opcode, 0);
        check("rst_halt", bus.halt, 0);
        check("rst_halt_code", bus.halt_code, 0);
        check("rst_retire_cnt", bus.retire_cnt, 0);
        exp_q.delete();
        exp_halt_q.delete();
        model_retire = 64'd0;
        stall_left   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic send(logic [7:0] op, logic mdu, logic eb, logic inv, int delay);
        logic [1:0] hc;
        int         n;
        hc = model_halt(mdu, eb, inv, delay);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b1;
        bus.in_opcode  = op;
        bus.in_is_mdu  = mdu;
        bus.in_ebreak  = eb;
        bus.in_invalid = inv;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 1, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        if (delay != ABANDON) begin
            if (hc != 2'b00) exp_halt_q.push_back(hc);
            else exp_q.push_back(op);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 8'($urandom);
        if (eb && !inv) model_retire = model_retire + 64'd1;
        @(negedge clk);
        check("out_opcode_latch", bus.out_opcode, {56'd0, op});
        if (inv || eb) begin
            check("halt_after_accept", bus.halt, 1);
            check("halt_no_alu", bus.alu_en, 0);
            check("halt_no_mdu", bus.mdu_start, 0);
            return;
        end
        check("alu_en_pulse", bus.alu_en, !mdu);
        check("mdu_start_pulse", bus.mdu_start, mdu);
        check("out_valid_next", bus.out_valid, !mdu);
        if (!mdu || delay == ABANDON) return;
        if (delay == NO_DONE) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                @(negedge clk);
                if (k == TIMEOUT - 1) check("timeout_early", bus.halt, 0);
                if (k == TIMEOUT) check("timeout_halt", bus.halt, 1);
            end
            return;
        end
        if (delay > 0) begin
            repeat (delay) begin
                @(posedge clk);
                #1;
            end
            bus.mdu_done = 1'b1;
            @(negedge clk);
            check("mdu_wait_valid", bus.out_valid, 0);
        end else begin
            bus.mdu_done = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.mdu_done = 1'b0;
        @(negedge clk);
        check("mdu_resp_latency", bus.out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || exp_halt_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                check("drain_timeout", exp_q.size() + exp_halt_q.size(), 0);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic poke_halted();
        repeat (5) begin
            @(posedge clk);
            #1;
            bus.in_valid   = 1'b1;
            bus.in_opcode  = 8'($urandom);
            bus.in_is_mdu  = 1'($urandom);
            bus.in_ebreak  = 1'($urandom);
            bus.in_invalid = 1'($urandom);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // writeback ready source
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) bus.out_ready = 1'b0;
            else bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor
    initial begin
        logic       prev_stall;
        logic       prev_pulse;
        logic       halt_seen;
        logic [1:0] halt_exp;
        prev_stall = 1'b0;
        prev_pulse = 1'b0;
        halt_seen  = 1'b0;
        halt_exp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 1'b0;
                prev_pulse = 1'b0;
                halt_seen  = 1'b0;
                continue;
            end
            check("retire_cnt", bus.retire_cnt, model_retire);
            check("pulse_exclusive", bus.alu_en & bus.mdu_start, 0);
            check("pulse_back_to_back", prev_pulse & (bus.alu_en | bus.mdu_start), 0);
            prev_pulse = bus.alu_en | bus.mdu_start;
            if (prev_stall) check("hold_valid", bus.out_valid, 1);
            prev_stall = 1'b0;
            if (bus.halt) begin
                if (!halt_seen) begin
                    halt_seen = 1'b1;
                    if (exp_halt_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_halt: halt_code %0b with none expected", bus.halt_code);
                    end else begin
                        halt_exp = exp_halt_q.pop_front();
                        check("halt_code", bus.halt_code, halt_exp);
                    end
                end else begin
                    check("halt_code_frozen", bus.halt_code, halt_exp);
                    check("halt_in_ready", bus.in_ready, 0);
                    check("halt_out_valid", bus.out_valid, 0);
                end
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: out_opcode %0h with none expected", bus.out_opcode);
                end else begin
                    check("resp_opcode", bus.out_opcode, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        model_retire = model_retire + 64'd1;
                    end else begin
                        prev_stall = 1'b1;
                        if (stall_left > 0) stall_left--;
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_opcode  = 8'h00;
        bus.in_is_mdu  = 1'b0;
        bus.in_ebreak  = 1'b0;
        bus.in_invalid = 1'b0;
        bus.mdu_done   = 1'b0;
        do_reset();

        send(8'h01, 1'b0, 1'b0, 1'b0, 0);
        stall_left = 3;
        send(8'h42, 1'b1, 1'b0, 1'b0, 5);
        send(8'h5a, 1'b1, 1'b0, 1'b0, TIMEOUT - 1);
        send(8'h33, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'($urandom), 1'b0, 1'b0, int'($urandom_range(0, TIMEOUT - 1)));
        end
        drain();

        @(posedge clk);
        #1;
        force dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
        model_retire = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_q;
        send(8'h77, 1'b0, 1'b0, 1'b0, 0);
        drain();
        check("retire_wrap", bus.retire_cnt, 0);

        send(8'h90, 1'b1, 1'b0, 1'b0, NO_DONE);
        poke_halted();
        drain();
        do_reset();

        send(8'h91, 1'b0, 1'b1, 1'b1, 0);
        poke_halted();
        drain();
        check("invalid_no_retire", bus.retire_cnt, 0);
        do_reset();

        send(8'h92, 1'b0, 1'b0, 1'b0, 0);
        send(8'h93, 1'b0, 1'b1, 1'b0, 0);
        poke_halted();
        drain();
        check("ebreak_retire", bus.retire_cnt, 2);
        do_reset();

        send(8'h94, 1'b1, 1'b0, 1'b0, ABANDON);
        repeat (3) @(posedge clk);
        do_reset();
        send(8'h95, 1'b0, 1'b0, 1'b0, 0);
        drain();
        check("post_reset_retire", bus.retire_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
